// File: rtl/router_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : router_ctrl                                                  |
// | Brief   : 1-to-3 packet router control FSM with optional FIFO          |
// |           read-timeout soft reset (ROUTER_SOFT_RESET_TIMEOUT_EN).      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module router_ctrl (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       low_pkt_valid,
  input  logic       parity_done,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] hdr_addr;
  logic       hdr_empty;
  logic       addr_full;
  logic       addr_empty;
  logic       addr_soft_reset;

  assign hdr_addr = data_in[1:0];
  assign vld_out  = ~fifo_empty;

  // Address 3 has no FIFO, so every per-destination select reads 0 for it.
  always_comb begin
    hdr_empty       = 1'b0;
    addr_full       = 1'b0;
    addr_empty      = 1'b0;
    addr_soft_reset = 1'b0;
    if (hdr_addr != 2'd3) hdr_empty = fifo_empty[hdr_addr];
    if (addr_q != 2'd3) begin
      addr_full       = fifo_full[addr_q];
      addr_empty      = fifo_empty[addr_q];
      addr_soft_reset = soft_reset[addr_q];
    end
  end

`ifdef ROUTER_SOFT_RESET_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LAST = 5'd29;

  for (genvar k = 0; k < 3; k++) begin : g_timeout
    logic [4:0] cnt_q, cnt_d;
    logic       sr_q, sr_d;

    always_comb begin
      sr_d  = 1'b0;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == TIMEOUT_LAST) begin
        sr_d  = 1'b1;
        cnt_d = 5'd0;
      end else if (read_enb[k] || !vld_out[k]) begin
        cnt_d = 5'd0;
      end
    end

    always_ff @(posedge clock) begin
      if (!resetn) begin
        cnt_q <= 5'd0;
        sr_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        sr_q  <= sr_d;
      end
    end

    assign soft_reset[k] = sr_q;
  end : g_timeout

  logic unused_data;
  assign unused_data = ^data_in[7:2];
`else
  assign soft_reset = 3'b000;

  logic unused_inputs;
  assign unused_inputs = ^{data_in[7:2], read_enb};
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = hdr_addr;

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && hdr_addr != 2'd3)
          state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (addr_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!addr_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = addr_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (addr_empty) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A timed-out destination FIFO aborts whatever the FSM was doing.
    if (addr_soft_reset) state_d = DECODE_ADDRESS;
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (addr_q)
        2'd0:    write_enb = 3'b001;
        2'd1:    write_enb = 3'b010;
        2'd2:    write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_router_ctrl                                               |
// | Brief   : Self-checking bench for router_ctrl (directed table, corner  |
// |           sequences, randomized run against a behavioural model).      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_router_ctrl;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, low_pkt_valid, parity_done;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  always #5 clock = ~clock;

  router_ctrl dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Decode vector: {detect, lfd, ld, laf, full, rst_int, write_enb_reg, busy}
  logic [7:0] dut_dec;
  assign dut_dec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    rst_int_reg, write_enb_reg, busy};

  localparam logic [7:0] D_DA  = 8'b1000_0000;
  localparam logic [7:0] D_LFD = 8'b0100_0001;
  localparam logic [7:0] D_LD  = 8'b0010_0010;
  localparam logic [7:0] D_LAF = 8'b0001_0011;
  localparam logic [7:0] D_FFS = 8'b0000_1001;
  localparam logic [7:0] D_LP  = 8'b0000_0011;
  localparam logic [7:0] D_CPE = 8'b0000_0101;
  localparam logic [7:0] D_WTE = 8'b0000_0001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: the state is just the decode pattern it shows.
  logic [7:0] m_dec = D_DA;
  int         m_addr = 0;
  int         m_cnt[3] = '{0, 0, 0};
  logic [2:0] m_sr = 3'b000;

  function automatic logic bitsel(input logic [2:0] v, input int a);
    return (a < 3) ? v[a] : 1'b0;
  endfunction

  function automatic void model_edge();
    logic [7:0] nxt;
    logic [2:0] new_sr;
    int         h;
    if (!resetn) begin
      m_dec = D_DA; m_addr = 0; m_sr = 3'b000;
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      return;
    end
    h   = int'(data_in[1:0]);
    nxt = m_dec;
    if (m_dec == D_DA) begin
      if (pkt_valid && h < 3) nxt = bitsel(fifo_empty, h) ? D_LFD : D_WTE;
    end else if (m_dec == D_LFD) nxt = D_LD;
    else if (m_dec == D_LD) begin
      if (bitsel(fifo_full, m_addr)) nxt = D_FFS;
      else if (!pkt_valid)           nxt = D_LP;
    end else if (m_dec == D_FFS) begin
      if (!bitsel(fifo_full, m_addr)) nxt = D_LAF;
    end else if (m_dec == D_LAF) nxt = parity_done ? D_DA : (low_pkt_valid ? D_LP : D_LD);
    else if (m_dec == D_LP) nxt = D_CPE;
    else if (m_dec == D_CPE) nxt = bitsel(fifo_full, m_addr) ? D_FFS : D_DA;
    else if (m_dec == D_WTE) begin
      if (bitsel(fifo_empty, m_addr)) nxt = D_LFD;
    end
    if (bitsel(m_sr, m_addr)) nxt = D_DA;
    if (m_dec == D_DA && pkt_valid) m_addr = h;
    new_sr = 3'b000;
`ifdef ROUTER_SOFT_RESET_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      new_sr[k] = (m_cnt[k] == 29);
      if (m_cnt[k] == 29 || read_enb[k] || fifo_empty[k]) m_cnt[k] = 0;
      else m_cnt[k] = m_cnt[k] + 1;
    end
`endif
    m_sr  = new_sr;
    m_dec = nxt;
  endfunction

  function automatic logic [16:0] model_bus();
    logic [2:0] we;
    we = 3'b000;
    if ((m_dec == D_LD || m_dec == D_LP || m_dec == D_LAF) && m_addr < 3)
      we = 3'(1 << m_addr);
    return {we, ~fifo_empty, m_sr, m_dec};
  endfunction

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    chk(tag, {15'd0, write_enb, vld_out, soft_reset, dut_dec}, {15'd0, model_bus()});
  endtask

  task automatic drive(input logic pv, input logic [7:0] d, input logic lo, input logic pd,
                       input logic [2:0] fl, input logic [2:0] em, input logic [2:0] rd);
    pkt_valid = pv; data_in = d; low_pkt_valid = lo; parity_done = pd;
    fifo_full = fl; fifo_empty = em; read_enb = rd;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b1, 8'h5E, 1'b1, 1'b1, 3'b111, 3'b000, 3'b000);
    step("reset");
    resetn = 1'b1;
  endtask

  typedef struct {
    logic       pv;
    logic [7:0] din;
    logic       lo, pd;
    logic [2:0] full, empty;
    logic [7:0] dec;
    logic [2:0] we;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic pv, input logic [7:0] din, input logic lo,
                              input logic pd, input logic [2:0] full, input logic [2:0] empty,
                              input logic [7:0] dec, input logic [2:0] we);
    vec_t v;
    v.pv = pv; v.din = din; v.lo = lo; v.pd = pd; v.full = full; v.empty = empty;
    v.dec = dec; v.we = we;
    tbl.push_back(v);
  endfunction

  initial begin
    resetn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);

    do_reset();
    chk("reset_dec", {24'd0, dut_dec}, {24'd0, D_DA});
    chk("reset_we", {29'd0, write_enb}, 32'd0);
    chk("reset_sr", {29'd0, soft_reset}, 32'd0);

    // addr 1 normal packet
    add(1, 8'h0D, 0, 0, 3'b000, 3'b111, D_LFD, 3'b000);
    add(1, 8'hA5, 0, 0, 3'b000, 3'b111, D_LD,  3'b010);
    add(1, 8'h3C, 0, 0, 3'b000, 3'b111, D_LD,  3'b010);
    add(1, 8'h5A, 0, 0, 3'b000, 3'b111, D_LD,  3'b010);
    add(0, 8'h77, 0, 0, 3'b000, 3'b111, D_LP,  3'b010);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_CPE, 3'b000);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_DA,  3'b000);
    // fifo 1 full for four cycles
    add(1, 8'h01, 0, 0, 3'b000, 3'b111, D_LFD, 3'b000);
    add(1, 8'h11, 0, 0, 3'b000, 3'b111, D_LD,  3'b010);
    for (int i = 0; i < 4; i++) add(1, 8'h22, 0, 0, 3'b010, 3'b111, D_FFS, 3'b000);
    add(1, 8'h33, 0, 0, 3'b000, 3'b111, D_LAF, 3'b010);
    add(1, 8'h44, 0, 0, 3'b000, 3'b111, D_LD,  3'b010);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_LP,  3'b010);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_CPE, 3'b000);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_DA,  3'b000);
    // addr 2 waits for its FIFO to drain
    add(1, 8'h02, 0, 0, 3'b000, 3'b011, D_WTE, 3'b000);
    add(0, 8'h00, 0, 0, 3'b000, 3'b011, D_WTE, 3'b000);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_LFD, 3'b000);
    add(1, 8'h99, 0, 0, 3'b000, 3'b111, D_LD,  3'b100);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_LP,  3'b100);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_CPE, 3'b000);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_DA,  3'b000);
    // addr 3 is ignored
    add(1, 8'h03, 0, 0, 3'b000, 3'b111, D_DA,  3'b000);
    add(1, 8'hFF, 0, 0, 3'b000, 3'b111, D_DA,  3'b000);
    // addr 0: full then parity_done
    add(1, 8'h00, 0, 0, 3'b000, 3'b111, D_LFD, 3'b000);
    add(1, 8'h10, 0, 0, 3'b000, 3'b111, D_LD,  3'b001);
    add(1, 8'h20, 0, 0, 3'b001, 3'b111, D_FFS, 3'b000);
    add(1, 8'h30, 0, 0, 3'b000, 3'b111, D_LAF, 3'b001);
    add(0, 8'h00, 0, 1, 3'b000, 3'b111, D_DA,  3'b000);
    // addr 0: low_pkt_valid, then full again at parity check
    add(1, 8'h00, 0, 0, 3'b000, 3'b111, D_LFD, 3'b000);
    add(1, 8'h10, 0, 0, 3'b000, 3'b111, D_LD,  3'b001);
    add(1, 8'h20, 0, 0, 3'b001, 3'b111, D_FFS, 3'b000);
    add(1, 8'h30, 0, 0, 3'b000, 3'b111, D_LAF, 3'b001);
    add(0, 8'h00, 1, 0, 3'b000, 3'b111, D_LP,  3'b001);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_CPE, 3'b000);
    add(0, 8'h00, 0, 0, 3'b001, 3'b111, D_FFS, 3'b000);
    add(0, 8'h00, 0, 0, 3'b000, 3'b111, D_LAF, 3'b001);
    add(0, 8'h00, 0, 1, 3'b000, 3'b111, D_DA,  3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pv, tbl[i].din, tbl[i].lo, tbl[i].pd, tbl[i].full, tbl[i].empty, 3'b000);
      step($sformatf("tbl_model[%0d]", i));
      chk($sformatf("tbl_dec[%0d]", i), {24'd0, dut_dec}, {24'd0, tbl[i].dec});
      chk($sformatf("tbl_we[%0d]", i), {29'd0, write_enb}, {29'd0, tbl[i].we});
      chk($sformatf("tbl_vld[%0d]", i), {29'd0, vld_out}, {29'd0, ~tbl[i].empty});
    end

    // reset in the middle of a packet drops it
    do_reset();
    drive(1, 8'h01, 0, 0, 3'b000, 3'b111, 3'b000); step("mid_hdr");
    drive(1, 8'h55, 0, 0, 3'b000, 3'b111, 3'b000); step("mid_lfd");
    step("mid_ld");
    chk("mid_ld_we", {29'd0, write_enb}, 32'h2);
    resetn = 1'b0;
    step("mid_rst");
    chk("mid_rst_dec", {24'd0, dut_dec}, {24'd0, D_DA});
    resetn = 1'b1;
    drive(0, 8'h00, 0, 0, 3'b000, 3'b111, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step("post_rst");
      chk("post_rst_we", {29'd0, write_enb}, 32'd0);
    end

`ifdef ROUTER_SOFT_RESET_TIMEOUT_EN
    // FIFO 0 unread for 30 cycles -> one soft_reset pulse, FSM aborts
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      drive(i == 1, 8'h00, 0, 0, 3'b000, 3'b110, 3'b000);
      step("to_model");
      chk($sformatf("to_sr[%0d]", i), {29'd0, soft_reset}, (i == 30) ? 32'h1 : 32'h0);
      if (i == 30) chk("to_busy30", {31'd0, busy}, 32'd1);
      if (i == 31) chk("to_detect31", {31'd0, detect_add}, 32'd1);
    end
    // a read at cycle 20 restarts the count, so no pulse in 40 cycles
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      drive(0, 8'h00, 0, 0, 3'b000, 3'b110, (i == 20) ? 3'b001 : 3'b000);
      step("rd_model");
      chk($sformatf("rd_sr[%0d]", i), {29'd0, soft_reset}, 32'd0);
    end
`endif

    // randomized run against the model
    do_reset();
    fifo_empty = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      resetn        = ($urandom_range(0, 199) != 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 8'($urandom);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      parity_done   = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) begin
        fifo_full[k] = ($urandom_range(0, 3) == 0);
        read_enb[k]  = ($urandom_range(0, 49) == 0);
      end
      if ($urandom_range(0, 19) == 0) fifo_empty[$urandom_range(0, 2)] ^= 1'b1;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
